// File: rtl/fma16_unpack.sv
// fp16 FMA operand stage: unpacks X/Y/Z into sign/exponent/mantissa plus class bits, one registered stage with valid/ready.
// Optional macro FMA16_UNPACK_SUBNORM_NORM_EN normalises subnormal mantissas (exp = 1 - lzc) instead of passing them raw.
module fma16_unpack #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      x_i,
    input  logic [15:0]      y_i,
    input  logic [15:0]      z_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       sgn_o,
    output logic [20:0]      exp_o,
    output logic [32:0]      mant_o,
    output logic [2:0]       nan_o,
    output logic [2:0]       snan_o,
    output logic [2:0]       inf_o,
    output logic [2:0]       zero_o,
    output logic [2:0]       sub_o,
    output logic [TAG_W-1:0] tag_o
);

    typedef struct packed {
        logic        sgn;
        logic [6:0]  exp;
        logic [10:0] mant;
        logic        nan;
        logic        snan;
        logic        inf;
        logic        zero;
        logic        sub;
    } unpk_t;

    function automatic unpk_t unpack(input logic [15:0] op);
        unpk_t      r;
        logic [4:0] e;
        logic [9:0] f;
`ifdef FMA16_UNPACK_SUBNORM_NORM_EN
        logic [3:0] lzc;
`endif
        // NOTE: every field gets a default first so no path leaves a value undriven (no latch).
        r     = '0;
        e     = op[14:10];
        f     = op[9:0];
        r.sgn = op[15];
        if (e == 5'd31) begin
            r.exp = 7'd31;
            if (f != 10'd0) begin
                r.nan  = 1'b1;
                r.snan = ~f[9];
                r.mant = {1'b1, f};
            end else begin
                r.inf  = 1'b1;
                r.mant = 11'h400;
            end
        end else if (e == 5'd0) begin
            if (f == 10'd0) begin
                r.zero = 1'b1;
            end else begin
                r.sub = 1'b1;
`ifdef FMA16_UNPACK_SUBNORM_NORM_EN
                // Highest set bit wins, giving leading zeros of {1'b0,f} in 1..10.
                lzc = 4'd10;
                for (int i = 0; i < 10; i++) begin
                    if (f[i]) lzc = 4'(10 - i);
                end
                r.mant = {1'b0, f} << lzc;
                r.exp  = 7'd1 - {3'b000, lzc};
`else
                r.exp  = 7'd1;
                r.mant = {1'b0, f};
`endif
            end
        end else begin
            r.exp  = {2'b00, e};
            r.mant = {1'b1, f};
        end
        return r;
    endfunction

    unpk_t            x_q, y_q, z_q;
    unpk_t            x_d, y_d, z_d;
    logic [TAG_W-1:0] tag_q;
    logic             valid_q, valid_d;
    logic             accept;

    assign in_ready = !valid_q | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        x_d     = unpack(x_i);
        y_d     = unpack(y_i);
        z_d     = unpack(z_i);
        valid_d = valid_q;
        if (accept) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: data registers are reset too, because every output must read 0 while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            tag_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            valid_q <= valid_d;
            if (accept) begin
                x_q   <= x_d;
                y_q   <= y_d;
                z_q   <= z_d;
                tag_q <= tag_i;
            end
        end
    end

    assign out_valid = valid_q;
    assign sgn_o     = {x_q.sgn,  y_q.sgn,  z_q.sgn};
    assign exp_o     = {x_q.exp,  y_q.exp,  z_q.exp};
    assign mant_o    = {x_q.mant, y_q.mant, z_q.mant};
    assign nan_o     = {x_q.nan,  y_q.nan,  z_q.nan};
    assign snan_o    = {x_q.snan, y_q.snan, z_q.snan};
    assign inf_o     = {x_q.inf,  y_q.inf,  z_q.inf};
    assign zero_o    = {x_q.zero, y_q.zero, z_q.zero};
    assign sub_o     = {x_q.sub,  y_q.sub,  z_q.sub};
    assign tag_o     = tag_q;

endmodule

// File: tb/tb_fma16_unpack.sv
// Self-checking bench for fma16_unpack: directed handshake/class cases, then randomized traffic against a value-level model.
module tb_fma16_unpack;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [15:0]      x_i, y_i, z_i;
    logic [TAG_W-1:0] tag_i, tag_o;
    logic [2:0]       sgn_o, nan_o, snan_o, inf_o, zero_o, sub_o;
    logic [20:0]      exp_o;
    logic [32:0]      mant_o;
    logic [75:0]      obs;

    int tests  = 0;
    int failed = 0;

    fma16_unpack #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_i(x_i), .y_i(y_i), .z_i(z_i), .tag_i(tag_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .sgn_o(sgn_o), .exp_o(exp_o), .mant_o(mant_o), .nan_o(nan_o),
        .snan_o(snan_o), .inf_o(inf_o), .zero_o(zero_o), .sub_o(sub_o), .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    assign obs = {sgn_o, exp_o, mant_o, nan_o, snan_o, inf_o, zero_o, sub_o, tag_o};

    typedef struct packed {
        logic        sgn;
        logic [6:0]  exp;
        logic [10:0] mant;
        logic        nan, snan, inf, zero, sub;
    } ref_t;

    // Value-level reference: subnormals are normalised by doubling until the hidden bit appears.
    function automatic ref_t ref_op(input logic [15:0] op);
        ref_t r;
        int   e  = int'(op[14:10]);
        int   f  = int'(op[9:0]);
        int   m;
        int   ex;
        r     = '0;
        r.sgn = op[15];
        if (e == 31 && f != 0) begin
            r.nan = 1'b1; r.snan = (f < 512); r.exp = 7'd31; r.mant = 11'(1024 + f);
        end else if (e == 31) begin
            r.inf = 1'b1; r.exp = 7'd31; r.mant = 11'd1024;
        end else if (e == 0 && f == 0) begin
            r.zero = 1'b1;
        end else if (e == 0) begin
            r.sub = 1'b1;
`ifdef FMA16_UNPACK_SUBNORM_NORM_EN
            m  = f;
            ex = 1;
            while (m < 1024) begin
                m  = m * 2;
                ex = ex - 1;
            end
            r.exp  = 7'(ex);
            r.mant = 11'(m);
`else
            m = f; ex = 1;
            r.exp  = 7'(ex);
            r.mant = 11'(m);
`endif
        end else begin
            r.exp = 7'(e); r.mant = 11'(1024 + f);
        end
        return r;
    endfunction

    function automatic logic [75:0] expect_vec(input logic [15:0] x, input logic [15:0] y,
                                               input logic [15:0] z, input logic [TAG_W-1:0] t);
        ref_t a, b, c;
        a = ref_op(x); b = ref_op(y); c = ref_op(z);
        return {a.sgn, b.sgn, c.sgn, a.exp, b.exp, c.exp, a.mant, b.mant, c.mant,
                a.nan, b.nan, c.nan, a.snan, b.snan, c.snan, a.inf, b.inf, c.inf,
                a.zero, b.zero, c.zero, a.sub, b.sub, c.sub, t};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [4:0] e;
        case ($urandom_range(0, 3))
            0:       e = 5'd0;
            1:       e = 5'd31;
            default: e = 5'($urandom_range(1, 30));
        endcase
        return {1'($urandom), e, 10'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
    endfunction

    task automatic check(input string tag, input logic [75:0] observed, input logic [75:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         input logic [TAG_W-1:0] t, input logic iv, input logic ordy);
        x_i = x; y_i = y; z_i = z; tag_i = t; in_valid = iv; out_ready = ordy;
    endtask

    logic [75:0] exp_q[$];
    logic [75:0] held;
    logic [15:0] rx, ry, rz;
    logic        model_full;

    initial begin
        rst_n = 1'b0;
        drive(16'h0, 16'h0, 16'h0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_valid", 76'(out_valid), 76'(0));
        check("reset_data", obs, 76'(0));
        check("reset_in_ready", 76'(in_ready), 76'(1));
        rst_n = 1'b1;

        // Basic accept, latency one cycle.
        drive(16'h3C00, 16'hC000, 16'h0000, 4'd1, 1'b1, 1'b0);
        @(negedge clk);
        drive(16'h7C01, 16'h7E00, 16'hFC00, 4'd2, 1'b1, 1'b0);
        #1;
        check("basic_valid", 76'(out_valid), 76'(1));
        check("basic_sgn", 76'(sgn_o), 76'(3'b010));
        check("basic_zero", 76'(zero_o), 76'(3'b001));
        check("basic_exp", 76'(exp_o), 76'({7'd15, 7'd16, 7'd0}));
        check("basic_mant", 76'(mant_o), 76'({11'h400, 11'h400, 11'h000}));
        check("basic_all", obs, expect_vec(16'h3C00, 16'hC000, 16'h0000, 4'd1));
        held = obs;

        // Full stage with downstream stalled for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 76'(in_ready), 76'(0));
            check("stall_valid", 76'(out_valid), 76'(1));
            check("stall_hold", obs, held);
        end
        out_ready = 1'b1;
        #1;
        check("drain_in_ready", 76'(in_ready), 76'(1));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("swap_valid", 76'(out_valid), 76'(1));
        check("special_nan", 76'(nan_o), 76'(3'b110));
        check("special_snan", 76'(snan_o), 76'(3'b100));
        check("special_inf", 76'(inf_o), 76'(3'b001));
        check("special_sgn", 76'(sgn_o), 76'(3'b001));
        check("special_exp", 76'(exp_o), 76'({7'd31, 7'd31, 7'd31}));
        check("special_all", obs, expect_vec(16'h7C01, 16'h7E00, 16'hFC00, 4'd2));
        held = obs;
        @(negedge clk);
        check("drain_valid", 76'(out_valid), 76'(0));
        check("drain_hold", obs, held);

        // Subnormals.
        drive(16'h0001, 16'h0200, 16'h8000, 4'd3, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("sub_flags", 76'(sub_o), 76'(3'b110));
        check("sub_zero", 76'(zero_o), 76'(3'b001));
`ifdef FMA16_UNPACK_SUBNORM_NORM_EN
        check("sub_exp", 76'(exp_o), 76'({7'h77, 7'h00, 7'h00}));
        check("sub_mant", 76'(mant_o), 76'({11'h400, 11'h400, 11'h000}));
`else
        check("sub_exp", 76'(exp_o), 76'({7'd1, 7'd1, 7'd0}));
        check("sub_mant", 76'(mant_o), 76'({11'h001, 11'h200, 11'h000}));
`endif
        check("sub_all", obs, expect_vec(16'h0001, 16'h0200, 16'h8000, 4'd3));

        // Eight back-to-back accepts, tags 0..7, no bubbles.
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                check("b2b_valid", 76'(out_valid), 76'(1));
                check("b2b_data", obs, exp_q.pop_front());
            end
            if (i < 8) begin
                rx = rand_op(); ry = rand_op(); rz = rand_op();
                drive(rx, ry, rz, 4'(i), 1'b1, 1'b1);
                exp_q.push_back(expect_vec(rx, ry, rz, 4'(i)));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_empty", 76'(out_valid), 76'(0));

        // Asynchronous reset in the middle of a cycle with a triple held.
        drive(16'h4248, 16'h8001, 16'h7C00, 4'd9, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_valid", 76'(out_valid), 76'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", 76'(out_valid), 76'(0));
        check("async_reset_data", obs, 76'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(16'h5A5A, 16'h0123, 16'hFE01, 4'd5, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("post_reset_valid", 76'(out_valid), 76'(1));
        check("post_reset_data", obs, expect_vec(16'h5A5A, 16'h0123, 16'hFE01, 4'd5));
        @(negedge clk);

        // Randomized traffic with scoreboard.
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            rx = rand_op(); ry = rand_op(); rz = rand_op();
            drive(rx, ry, rz, 4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
            #1;
            model_full = (exp_q.size() != 0);
            check("rand_valid", 76'(out_valid), 76'(model_full));
            check("rand_in_ready", 76'(in_ready), 76'(!model_full || out_ready));
            if (model_full && out_ready) check("rand_data", obs, exp_q.pop_front());
            if (in_valid && (!model_full || out_ready)) exp_q.push_back(expect_vec(rx, ry, rz, tag_i));
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
